// File: rtl/rv32_pkg.sv
// Shared RV32 fetch-path types and constants.
package rv32_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;
    localparam logic [XLEN-1:0] PC_STEP = 32'd4;

    // One fetched instruction together with the address it came from.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/ifetch_fifo.sv
// Small fetch buffer: power-of-two depth, registered head, flush beats push.
module ifetch_fifo
    import rv32_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  fetch_entry_t       push_data,
    input  logic               pop,
    input  logic               flush,
    output logic [CNT_W-1:0]   count,
    output fetch_entry_t       head
);

    fetch_entry_t           mem_q [DEPTH];
    fetch_entry_t           mem_d [DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   do_pop;

    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    // Next-state for storage, pointers and occupancy; pointers wrap naturally.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_pop   = pop && (count_q != '0);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(do_pop);
        end
    end

    // State registers; storage is cleared on reset so the head reads zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch front end: fetch PC, one-deep in-flight tracking against a
// registered-read memory, credit-based issue into the fetch buffer, redirect.
// Handshake: a head entry transfers on a rising edge where out_valid and
// out_ready are both high; out_* stay stable while out_valid=1 and not taken.
module ifetch_unit
    import rv32_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic             inflight_vld_q, inflight_vld_d;
    logic [31:0]      inflight_pc_q, inflight_pc_d;
    logic [CNT_W-1:0] count;
    fetch_entry_t     head;
    fetch_entry_t     push_data;
    logic             pop;
    logic             push;
    logic             issue;
    logic [31:0]      occupancy;

    assign imem_addr = fetch_pc_q;
    assign out_valid = (count != '0);
    assign pop       = out_valid & out_ready;
    assign out_pc    = head.pc;
    assign out_instr = head.instr;

    // Credit check, capture and PC/in-flight next state; redirect wins over all.
    always_comb begin
        occupancy      = 32'(count) + {31'b0, inflight_vld_q} - {31'b0, pop};
        issue          = !redirect_valid && (occupancy < 32'(FIFO_DEPTH));
        push           = inflight_vld_q && !redirect_valid;
        push_data      = '{pc: inflight_pc_q, instr: imem_rdata};
        fetch_pc_d     = fetch_pc_q;
        inflight_vld_d = 1'b0;
        inflight_pc_d  = inflight_pc_q;
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc & ~32'h3;
        end else if (issue) begin
            fetch_pc_d     = fetch_pc_q + PC_STEP;
            inflight_vld_d = 1'b1;
            inflight_pc_d  = fetch_pc_q;
        end
    end

    // Fetch PC and in-flight tracking registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q     <= RESET_PC;
            inflight_vld_q <= 1'b0;
            inflight_pc_q  <= '0;
        end else begin
            fetch_pc_q     <= fetch_pc_d;
            inflight_vld_q <= inflight_vld_d;
            inflight_pc_q  <= inflight_pc_d;
        end
    end

    ifetch_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_data(push_data),
        .pop      (pop),
        .flush    (redirect_valid),
        .count    (count),
        .head     (head)
    );

endmodule
